// File: rtl/tap_sequencer.sv
// Tap sequencer: latches one sample per handshake, sweeps the tap index 0..N_TAPS-1
// under clk_enable, then pulses result_valid; all outputs registered.
module tap_sequencer #(
    parameter int COUNT_WIDTH = 6,
    parameter int N_TAPS      = 64,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_enable,
    input  logic signed [DATA_WIDTH-1:0]  sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          overrun_clear,
    output logic signed [DATA_WIDTH-1:0]  sample_out,
    output logic [COUNT_WIDTH-1:0]        current_count,
    output logic                          count_active,
    output logic                          sample_load,
    output logic                          accum_clear,
    output logic                          result_valid,
    output logic                          overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_TAP = COUNT_WIDTH'(N_TAPS - 1);

    state_t                         state, state_nxt;
    logic [COUNT_WIDTH-1:0]         count_nxt;
    logic signed [DATA_WIDTH-1:0]   sample_nxt;
    logic                           active_nxt;
    logic                           ready_nxt;
    logic                           load_nxt;
    logic                           clear_nxt;
    logic                           result_nxt;
    logic                           overrun_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            current_count <= '0;
            sample_out    <= '0;
            count_active  <= 1'b0;
            sample_ready  <= 1'b1;
            sample_load   <= 1'b0;
            accum_clear   <= 1'b0;
            result_valid  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nxt;
            current_count <= count_nxt;
            sample_out    <= sample_nxt;
            count_active  <= active_nxt;
            sample_ready  <= ready_nxt;
            sample_load   <= load_nxt;
            accum_clear   <= clear_nxt;
            result_valid  <= result_nxt;
            overrun       <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = current_count;
        sample_nxt  = sample_out;
        active_nxt  = count_active;
        ready_nxt   = sample_ready;
        load_nxt    = 1'b0;
        clear_nxt   = 1'b0;
        result_nxt  = 1'b0;
        overrun_nxt = overrun;

        // A dropped sample outranks a simultaneous clear so no overrun is ever lost.
        if (overrun_clear)
            overrun_nxt = 1'b0;
        if (sample_valid && clk_enable && !sample_ready)
            overrun_nxt = 1'b1;

        case (state)
            IDLE: begin
                count_nxt = '0;
                ready_nxt = 1'b1;
                if (sample_valid && clk_enable) begin
                    sample_nxt = sample_in;
                    state_nxt  = RUN;
                    active_nxt = 1'b1;
                    ready_nxt  = 1'b0;
                    load_nxt   = 1'b1;
                    clear_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (clk_enable) begin
                    if (current_count == LAST_TAP) begin
                        count_nxt  = '0;
                        state_nxt  = DONE;
                        active_nxt = 1'b0;
                        result_nxt = 1'b1;
                    end else begin
                        count_nxt = current_count + COUNT_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_nxt  = IDLE;
                ready_nxt  = 1'b1;
                active_nxt = 1'b0;
                count_nxt  = '0;
            end
            default: begin
                state_nxt  = IDLE;
                count_nxt  = '0;
                active_nxt = 1'b0;
                ready_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench for tap_sequencer: a 64-tap instance and a 5-tap instance share stimulus.
module tb_tap_sequencer;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clk_enable = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               overrun_clear = 1'b0;

    logic               sample_ready, count_active, sample_load, accum_clear, result_valid, overrun;
    logic signed [15:0] sample_out;
    logic [5:0]         current_count;

    logic               s_ready, s_active, s_load, s_clear, s_result, s_overrun;
    logic signed [15:0] s_out;
    logic [5:0]         s_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tap_sequencer #(.COUNT_WIDTH(6), .N_TAPS(64), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun_clear(overrun_clear), .sample_out(sample_out), .current_count(current_count),
        .count_active(count_active), .sample_load(sample_load), .accum_clear(accum_clear),
        .result_valid(result_valid), .overrun(overrun)
    );

    tap_sequencer #(.COUNT_WIDTH(6), .N_TAPS(5), .DATA_WIDTH(16)) dut5 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(s_ready),
        .overrun_clear(overrun_clear), .sample_out(s_out), .current_count(s_count),
        .count_active(s_active), .sample_load(s_load), .accum_clear(s_clear),
        .result_valid(s_result), .overrun(s_overrun)
    );

    // Outputs are sampled 1 ns after the edge; inputs set then apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sample_valid  = 1'b0;
        overrun_clear = 1'b0;
        clk_enable    = 1'b0;
        reset         = 1'b1;
        step();
        reset         = 1'b0;
    endtask

    task automatic accept(input logic [15:0] val);
        clk_enable   = 1'b1;
        sample_in    = val;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (current_count !== 6'd0) begin fails++; $display("FAIL reset_count got %0d want 0", current_count); end
        tests++; if (sample_out !== 16'h0000) begin fails++; $display("FAIL reset_sample got %h want 0000", sample_out); end
        tests++; if ({count_active, sample_load, accum_clear, result_valid, overrun} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {count_active, sample_load, accum_clear, result_valid, overrun}); end
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", sample_ready); end
    endtask

    task automatic test_sweep();
        do_reset();
        accept(16'h1234);
        tests++; if ({sample_load, accum_clear} !== 2'b11) begin fails++; $display("FAIL sweep_pulse_on got %b want 11", {sample_load, accum_clear}); end
        tests++; if (sample_out !== 16'h1234) begin fails++; $display("FAIL sweep_sample got %h want 1234", sample_out); end
        tests++; if (current_count !== 6'd0 || count_active !== 1'b1 || sample_ready !== 1'b0) begin
            fails++; $display("FAIL sweep_start got cnt=%0d act=%b rdy=%b want 0 1 0", current_count, count_active, sample_ready); end
        for (int k = 1; k < 64; k++) begin
            step();
            tests++; if (current_count !== 6'(k) || count_active !== 1'b1 || result_valid !== 1'b0) begin
                fails++; $display("FAIL sweep_count got cnt=%0d act=%b rv=%b want %0d 1 0", current_count, count_active, result_valid, k); end
            if (k == 1) begin
                tests++; if ({sample_load, accum_clear} !== 2'b00) begin fails++; $display("FAIL sweep_pulse_off got %b want 00", {sample_load, accum_clear}); end
            end
        end
        step();
        tests++; if (result_valid !== 1'b1 || count_active !== 1'b0 || current_count !== 6'd0 || sample_ready !== 1'b0) begin
            fails++; $display("FAIL sweep_done got rv=%b act=%b cnt=%0d rdy=%b want 1 0 0 0", result_valid, count_active, current_count, sample_ready); end
        step();
        tests++; if (result_valid !== 1'b0 || sample_ready !== 1'b1) begin
            fails++; $display("FAIL sweep_idle got rv=%b rdy=%b want 0 1", result_valid, sample_ready); end
    endtask

    task automatic test_stall();
        do_reset();
        accept(16'h1234);
        for (int c = 1; c <= 126; c++) begin
            clk_enable = (c % 2 == 0);
            step();
            tests++; if (current_count !== 6'(c / 2) || count_active !== 1'b1) begin
                fails++; $display("FAIL stall_count c=%0d got cnt=%0d act=%b want %0d 1", c, current_count, count_active, c / 2); end
        end
        clk_enable = 1'b0;
        step();
        tests++; if (current_count !== 6'd63 || result_valid !== 1'b0 || count_active !== 1'b1) begin
            fails++; $display("FAIL stall_last_hold got cnt=%0d rv=%b act=%b want 63 0 1", current_count, result_valid, count_active); end
        clk_enable = 1'b1;
        step();
        tests++; if (result_valid !== 1'b1 || current_count !== 6'd0) begin
            fails++; $display("FAIL stall_done got rv=%b cnt=%0d want 1 0", result_valid, current_count); end
        clk_enable = 1'b0;
        step();
        tests++; if (result_valid !== 1'b0 || sample_ready !== 1'b1) begin
            fails++; $display("FAIL stall_done_len got rv=%b rdy=%b want 0 1", result_valid, sample_ready); end
    endtask

    task automatic test_overrun();
        do_reset();
        accept(16'h1234);
        for (int k = 1; k <= 20; k++) step();
        sample_in    = 16'hBEEF;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        tests++; if (overrun !== 1'b1 || sample_out !== 16'h1234 || current_count !== 6'd21) begin
            fails++; $display("FAIL overrun_set got ovr=%b out=%h cnt=%0d want 1 1234 21", overrun, sample_out, current_count); end
        for (int k = 22; k <= 64; k++) step();
        tests++; if (result_valid !== 1'b1 || sample_out !== 16'h1234) begin
            fails++; $display("FAIL overrun_sweep got rv=%b out=%h want 1 1234", result_valid, sample_out); end
        step();
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear got %b want 0", overrun); end
        accept(16'h0042);
        sample_valid  = 1'b1;
        overrun_clear = 1'b1;
        step();
        sample_valid  = 1'b0;
        overrun_clear = 1'b0;
        tests++; if (overrun !== 1'b1 || sample_out !== 16'h0042) begin
            fails++; $display("FAIL overrun_set_wins got ovr=%b out=%h want 1 0042", overrun, sample_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        accept(16'h1234);
        for (int k = 1; k <= 40; k++) step();
        tests++; if (current_count !== 6'd40) begin fails++; $display("FAIL midreset_pre got %0d want 40", current_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (current_count !== 6'd0 || sample_out !== 16'h0000 || sample_ready !== 1'b1 ||
                     {count_active, sample_load, accum_clear, result_valid, overrun} !== 5'b0) begin
            fails++; $display("FAIL midreset_vals got cnt=%0d out=%h rdy=%b flags=%b want 0 0000 1 00000",
                current_count, sample_out, sample_ready, {count_active, sample_load, accum_clear, result_valid, overrun}); end
        for (int k = 0; k < 30; k++) begin
            step();
            tests++; if (result_valid !== 1'b0 || current_count !== 6'd0 || count_active !== 1'b0) begin
                fails++; $display("FAIL midreset_idle got rv=%b cnt=%0d act=%b want 0 0 0", result_valid, current_count, count_active); end
        end
        accept(16'h5A5A);
        tests++; if (sample_load !== 1'b1 || sample_out !== 16'h5A5A || count_active !== 1'b1) begin
            fails++; $display("FAIL midreset_accept got ld=%b out=%h act=%b want 1 5a5a 1", sample_load, sample_out, count_active); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clk_enable   = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'hA000;
        step();
        tests++; if (sample_load !== 1'b1 || sample_out !== 16'hA000) begin
            fails++; $display("FAIL b2b_first got ld=%b out=%h want 1 a000", sample_load, sample_out); end
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 1; i <= 66; i++) begin
                sample_in = 16'hA000 + 16'(rep * 100 + i);
                step();
                tests++; if (sample_load !== (i == 66)) begin
                    fails++; $display("FAIL b2b_load rep=%0d i=%0d got %b want %b", rep, i, sample_load, (i == 66)); end
                if (i == 1) begin
                    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun got %b want 1", overrun); end
                end
            end
            tests++; if (sample_out !== 16'hA000 + 16'(rep * 100 + 66)) begin
                fails++; $display("FAIL b2b_sample got %h want %h", sample_out, 16'hA000 + 16'(rep * 100 + 66)); end
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_short_sweep();
        do_reset();
        accept(16'h0777);
        tests++; if (s_count !== 6'd0 || s_load !== 1'b1) begin
            fails++; $display("FAIL short_start got cnt=%0d ld=%b want 0 1", s_count, s_load); end
        for (int k = 1; k <= 4; k++) begin
            step();
            tests++; if (s_count !== 6'(k) || s_result !== 1'b0) begin
                fails++; $display("FAIL short_count got cnt=%0d rv=%b want %0d 0", s_count, s_result, k); end
        end
        step();
        tests++; if (s_count !== 6'd0 || s_result !== 1'b1 || s_active !== 1'b0) begin
            fails++; $display("FAIL short_wrap got cnt=%0d rv=%b act=%b want 0 1 0", s_count, s_result, s_active); end
        step();
        tests++; if (s_result !== 1'b0 || s_ready !== 1'b1 || s_count !== 6'd0) begin
            fails++; $display("FAIL short_idle got rv=%b rdy=%b cnt=%0d want 0 1 0", s_result, s_ready, s_count); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_short_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
